// File: rtl/arb_pkg.sv
// Shared types for the req/grant arbitration clients: command record, client
// state encoding and the default starvation threshold.
package arb_pkg;

  localparam int unsigned CMD_AW         = 32;
  localparam int unsigned CMD_LW         = 4;
  localparam int unsigned STARVE_CYC_DEF = 64;

  typedef struct packed {
    logic [CMD_AW-1:0] addr;
    logic [CMD_LW-1:0] len;
  } cmd_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } client_state_e;

endpackage

// File: rtl/arb_req_client_if.sv
// Command handshake plus arbiter/bus signals of one arbiter client.
// master = client side, slave = engine/arbiter/bus side.
interface arb_req_client_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned LW = 4
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          req;
  logic          grant;
  logic          bus_valid;
  logic [AW-1:0] bus_addr;
  logic          bus_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, grant,
    output cmd_ready, req, bus_valid, bus_addr, bus_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, grant,
    input  cmd_ready, req, bus_valid, bus_addr, bus_last
  );

endinterface

// File: rtl/arb_cmd_fifo.sv
// Burst command FIFO: DEPTH entries of type T, registered full/empty flags,
// read/write pointers with an extra wrap bit. Head entry is shown combinationally.
module arb_cmd_fifo
  import arb_pkg::*;
#(
  parameter type         T     = cmd_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  T           mem_q [DEPTH];
  logic [PW:0] wr_q, wr_d, rd_q, rd_d;
  logic        full_q, full_d, empty_q, empty_d;
  logic        do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    wr_d    = do_push ? wr_q + (PW+1)'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + (PW+1)'(1) : rd_q;
    empty_d = (wr_d == rd_d);
    full_d  = (wr_d[PW] != rd_d[PW]) && (wr_d[PW-1:0] == rd_d[PW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rd_q[PW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/arb_req_client.sv
// Requester endpoint of the round-robin req/grant arbiter: queues burst commands,
// raises a registered req and emits one beat per granted cycle.
// Optional ARB_REQ_CLIENT_STARVE_EN adds a sticky starve flag (STARVE_CYC threshold).
module arb_req_client
  import arb_pkg::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned LW    = 4,
  parameter int unsigned DEPTH = 4
`ifdef ARB_REQ_CLIENT_STARVE_EN
  ,
  parameter int unsigned STARVE_CYC = STARVE_CYC_DEF
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  arb_req_client_if.master        cif,
  output logic                    busy,
  output logic                    done
`ifdef ARB_REQ_CLIENT_STARVE_EN
  ,
  output logic                    starve
`endif
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } cmd_w_t;

  client_state_e state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [LW-1:0] cur_len_q, cur_len_d;
  logic [LW-1:0] beat_q, beat_d;
  logic          req_q, req_d;
  logic          done_q, done_d;

  cmd_w_t push_cmd, head_cmd;
  logic   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic   xfer, last;

  assign push_cmd  = '{addr: cif.cmd_addr, len: cif.cmd_len};
  assign fifo_push = cif.cmd_valid & ~fifo_full;

  arb_cmd_fifo #(
    .T     (cmd_w_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (push_cmd),
    .pop_i   (fifo_pop),
    .data_o  (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // grant is only honoured while our registered req is up
  assign xfer = req_q & cif.grant;
  assign last = (beat_q == cur_len_q);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    cur_len_d  = cur_len_q;
    beat_d     = beat_q;
    fifo_pop   = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          cur_addr_d = head_cmd.addr;
          cur_len_d  = head_cmd.len;
          beat_d     = '0;
          state_d    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (xfer) begin
          if (last) begin
            done_d = 1'b1;
            // chain the next queued burst without dropping req
            if (!fifo_empty) begin
              fifo_pop   = 1'b1;
              cur_addr_d = head_cmd.addr;
              cur_len_d  = head_cmd.len;
              beat_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_d = beat_q + LW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      cur_len_q  <= '0;
      beat_q     <= '0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      cur_len_q  <= cur_len_d;
      beat_q     <= beat_d;
      req_q      <= req_d;
      done_q     <= done_d;
    end
  end

  assign cif.cmd_ready = ~fifo_full;
  assign cif.req       = req_q;
  assign cif.bus_valid = xfer;
  assign cif.bus_addr  = cur_addr_q + AW'(beat_q);
  assign cif.bus_last  = last;
  assign busy          = ~fifo_empty | (state_q == ACTIVE);
  assign done          = done_q;

`ifdef ARB_REQ_CLIENT_STARVE_EN
  logic [15:0] starve_cnt_q, starve_cnt_d;
  logic        starve_q;

  always_comb begin
    starve_cnt_d = '0;
    if (state_q == ACTIVE && !cif.grant)
      starve_cnt_d = (starve_cnt_q == '1) ? starve_cnt_q : starve_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      if (starve_cnt_d >= 16'(STARVE_CYC)) starve_q <= 1'b1;
    end
  end

  assign starve = starve_q;
`endif

endmodule
